// File: rtl/round_ctrl.sv
// round_ctrl: sequences one quiz game of ROUNDS rounds around an external
// countdown timer. Button presses are synchronised and edge-detected. The
// timer is reset for one cycle and then run in each round. A correct answer
// adds the remaining seconds to a saturating score.
//
// Parameters:
//   ROUNDS     rounds per game (1..15)
//   SCORE_MAX  score saturation ceiling (fits 12 bits)
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   start_btn   async start button (active-high)
//   answer_btn  async answer button (active-high)
//   answer_ok   answer-correct flag, sampled when an answer is detected
//   t_in        seconds remaining from the timer
//   t_done      timer expired flag
//   tmr_rst_n   active-low timer reset (high only in RUN and SCORE)
//   tmr_en      timer enable (high only in RUN)
//   score       accumulated score
//   round       completed rounds, 0..ROUNDS
//   busy        high while a game is in progress (ARM/RUN/SCORE/NEXT)
//   game_over   high in OVER
// Build option:
//   ROUND_CTRL_BONUS_EN  a correct answer with t_in >= 20 scores t_in+10
module round_ctrl #(
  parameter int unsigned ROUNDS    = 5,
  parameter int unsigned SCORE_MAX = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_btn,
  input  logic        answer_btn,
  input  logic        answer_ok,
  input  logic [7:0]  t_in,
  input  logic        t_done,
  output logic        tmr_rst_n,
  output logic        tmr_en,
  output logic [11:0] score,
  output logic [3:0]  round,
  output logic        busy,
  output logic        game_over
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    RUN   = 3'd2,
    SCORE = 3'd3,
    NEXT  = 3'd4,
    OVER  = 3'd5
  } state_t;

  localparam logic [12:0] SCORE_CAP  = 13'(SCORE_MAX);
  localparam logic [3:0]  ROUND_LAST = 4'(ROUNDS);

  state_t      state;
  logic [2:0]  start_sync;
  logic [2:0]  answer_sync;
  logic        start_edge;
  logic        answer_edge;
  logic [7:0]  lat_t;
  logic        lat_ok;
  logic [8:0]  add_val;
  logic [12:0] sum;
  logic [11:0] score_sat;
  logic [3:0]  round_inc;

  // Two synchroniser flops, one history flop, and a registered edge pulse.
  // The pulse is therefore seen three cycles after the button rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_sync  <= '0;
      answer_sync <= '0;
      start_edge  <= 1'b0;
      answer_edge <= 1'b0;
    end else begin
      start_sync  <= {start_sync[1:0], start_btn};
      answer_sync <= {answer_sync[1:0], answer_btn};
      start_edge  <= start_sync[1] & ~start_sync[2];
      answer_edge <= answer_sync[1] & ~answer_sync[2];
    end
  end

  always_comb begin
    add_val = {1'b0, lat_t};
`ifdef ROUND_CTRL_BONUS_EN
    if (lat_t >= 8'd20) begin
      add_val = {1'b0, lat_t} + 9'd10;
    end
`endif
    sum       = {1'b0, score} + {4'b0, add_val};
    score_sat = (sum > SCORE_CAP) ? SCORE_CAP[11:0] : sum[11:0];
    round_inc = round + 4'd1;
  end

  // Output bits {tmr_rst_n, tmr_en, busy, game_over} for the state being
  // entered. They are registered together with the state, so they change
  // on the same edge as the state.
  function automatic logic [3:0] outs(input state_t s);
    case (s)
      ARM:     outs = 4'b0010;
      RUN:     outs = 4'b1110;
      SCORE:   outs = 4'b1010;
      NEXT:    outs = 4'b0010;
      OVER:    outs = 4'b0001;
      default: outs = 4'b0000;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      score     <= '0;
      round     <= '0;
      lat_t     <= '0;
      lat_ok    <= 1'b0;
      tmr_rst_n <= 1'b0;
      tmr_en    <= 1'b0;
      busy      <= 1'b0;
      game_over <= 1'b0;
    end else begin
      case (state)
        IDLE, OVER: begin
          if (start_edge) begin
            score <= '0;
            round <= '0;
            state <= ARM;
            {tmr_rst_n, tmr_en, busy, game_over} <= outs(ARM);
          end
        end
        ARM: begin
          state <= RUN;
          {tmr_rst_n, tmr_en, busy, game_over} <= outs(RUN);
        end
        RUN: begin
          // An expiry beats an answer that arrives in the same cycle.
          if (t_done) begin
            state <= NEXT;
            {tmr_rst_n, tmr_en, busy, game_over} <= outs(NEXT);
          end else if (answer_edge) begin
            lat_t  <= t_in;
            lat_ok <= answer_ok;
            state  <= SCORE;
            {tmr_rst_n, tmr_en, busy, game_over} <= outs(SCORE);
          end
        end
        SCORE: begin
          if (lat_ok) begin
            score <= score_sat;
          end
          state <= NEXT;
          {tmr_rst_n, tmr_en, busy, game_over} <= outs(NEXT);
        end
        NEXT: begin
          round <= round_inc;
          if (round_inc == ROUND_LAST) begin
            state <= OVER;
            {tmr_rst_n, tmr_en, busy, game_over} <= outs(OVER);
          end else begin
            state <= ARM;
            {tmr_rst_n, tmr_en, busy, game_over} <= outs(ARM);
          end
        end
        default: begin
          state <= IDLE;
          {tmr_rst_n, tmr_en, busy, game_over} <= outs(IDLE);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_round_ctrl.sv
module tb_round_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_btn = 1'b0;
  logic        answer_btn = 1'b0;
  logic        answer_ok = 1'b0;
  logic [7:0]  t_in = '0;
  logic        t_done = 1'b0;
  logic        tmr_rst_n, tmr_en, busy, game_over;
  logic [11:0] score;
  logic [3:0]  round;
  logic        s_tmr_rst_n, s_tmr_en, s_busy, s_game_over;
  logic [11:0] s_score;
  logic [3:0]  s_round;

  always #5 clk = ~clk;

  round_ctrl #(.ROUNDS(5), .SCORE_MAX(4095)) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .answer_btn(answer_btn),
    .answer_ok(answer_ok), .t_in(t_in), .t_done(t_done),
    .tmr_rst_n(tmr_rst_n), .tmr_en(tmr_en), .score(score), .round(round),
    .busy(busy), .game_over(game_over)
  );

  // Same stimulus, low ceiling, to exercise saturation.
  round_ctrl #(.ROUNDS(5), .SCORE_MAX(50)) dut_sat (
    .clk(clk), .rst(rst), .start_btn(start_btn), .answer_btn(answer_btn),
    .answer_ok(answer_ok), .t_in(t_in), .t_done(t_done),
    .tmr_rst_n(s_tmr_rst_n), .tmr_en(s_tmr_en), .score(s_score), .round(s_round),
    .busy(s_busy), .game_over(s_game_over)
  );

  typedef struct {
    int kind;   // 0 answer, 1 timeout, 2 timeout with same-cycle answer edge
    int t;
    int ok;
    int exp_round;
    int exp_over;
  } vec_t;

  typedef struct {
    int sc;
    int sc_sat;
    int rnd;
    int ovr;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   m_score = 0;
  int   m_score_sat = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_add(input int cur, input int t, input int ok, input int cap);
    int a;
    if (ok == 0) return cur;
    a = t;
`ifdef ROUND_CTRL_BONUS_EN
    if (t >= 20) a = t + 10;
`endif
    return (cur + a > cap) ? cap : cur + a;
  endfunction

  task automatic wait_run();
    int n = 0;
    while (tmr_en !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (tmr_en !== 1'b1) chk("run_timeout", 0, 1);
  endtask

  task automatic press_start();
    int n = 0;
    start_btn = 1'b1;
    repeat (2) @(negedge clk);
    start_btn = 1'b0;
    while (busy !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("arm_reached", int'(busy), 1);
    chk("arm_tmr_rst_n", int'(tmr_rst_n), 0);
    chk("arm_tmr_en", int'(tmr_en), 0);
    chk("arm_score", int'(score), 0);
    chk("arm_round", int'(round), 0);
    chk("arm_sat_score", int'(s_score), 0);
    chk("arm_game_over", int'(game_over), 0);
    @(negedge clk);
    chk("run_tmr_rst_n", int'(tmr_rst_n), 1);
    chk("run_tmr_en", int'(tmr_en), 1);
    chk("run_busy", int'(busy), 1);
    m_score = 0;
    m_score_sat = 0;
  endtask

  task automatic play(input vec_t v, input int idx);
    exp_t e;
    exp_t got;
    int   old_round;
    int   n = 0;
    wait_run();
    old_round = int'(round);
    case (v.kind)
      0: begin
        t_in = 8'(v.t);
        answer_ok = (v.ok != 0);
        answer_btn = 1'b1;
        repeat (2) @(negedge clk);
        answer_btn = 1'b0;
        m_score = model_add(m_score, v.t, v.ok, 4095);
        m_score_sat = model_add(m_score_sat, v.t, v.ok, 50);
      end
      1: begin
        t_done = 1'b1;
        @(negedge clk);
        t_done = 1'b0;
      end
      default: begin
        // Answer edge reaches the FSM on the 4th rising edge after the press.
        t_in = 8'(v.t);
        answer_ok = 1'b1;
        answer_btn = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        t_done = 1'b1;
        answer_btn = 1'b0;
        @(negedge clk);
        t_done = 1'b0;
      end
    endcase
    e.sc = m_score;
    e.sc_sat = m_score_sat;
    e.rnd = v.exp_round;
    e.ovr = v.exp_over;
    sb.push_back(e);
    while (int'(round) == old_round && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (int'(round) == old_round) chk($sformatf("round_timeout_%0d", idx), 0, 1);
    got = sb.pop_front();
    chk($sformatf("score_%0d", idx), int'(score), got.sc);
    chk($sformatf("sat_score_%0d", idx), int'(s_score), got.sc_sat);
    chk($sformatf("round_%0d", idx), int'(round), got.rnd);
    chk($sformatf("game_over_%0d", idx), int'(game_over), got.ovr);
    chk($sformatf("busy_%0d", idx), int'(busy), 1 - got.ovr);
  endtask

  initial begin
    vecs[0] = '{kind: 0, t: 17, ok: 1, exp_round: 1, exp_over: 0};
    vecs[1] = '{kind: 2, t: 25, ok: 1, exp_round: 2, exp_over: 0};
    vecs[2] = '{kind: 0, t: 30, ok: 1, exp_round: 1, exp_over: 0};
    vecs[3] = '{kind: 0, t: 0,  ok: 1, exp_round: 2, exp_over: 0};
    vecs[4] = '{kind: 0, t: 12, ok: 1, exp_round: 3, exp_over: 0};
    vecs[5] = '{kind: 0, t: 9,  ok: 0, exp_round: 4, exp_over: 0};
    vecs[6] = '{kind: 1, t: 0,  ok: 0, exp_round: 5, exp_over: 1};
    vecs[7] = '{kind: 0, t: 30, ok: 1, exp_round: 1, exp_over: 0};
    vecs[8] = '{kind: 0, t: 30, ok: 1, exp_round: 2, exp_over: 0};

    // Reset state
    #12;
    chk("rst_score", int'(score), 0);
    chk("rst_round", int'(round), 0);
    chk("rst_tmr_rst_n", int'(tmr_rst_n), 0);
    chk("rst_tmr_en", int'(tmr_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_game_over", int'(game_over), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Game 1: answer, then expiry colliding with an answer, then reset in round 3
    press_start();
    for (int i = 0; i < 2; i++) play(vecs[i], i);
    wait_run();
    chk("r3_running", int'(tmr_en), 1);
    rst = 1'b0;
    #1;
    chk("midrst_score", int'(score), 0);
    chk("midrst_round", int'(round), 0);
    chk("midrst_tmr_rst_n", int'(tmr_rst_n), 0);
    chk("midrst_tmr_en", int'(tmr_en), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_game_over", int'(game_over), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Answer presses in IDLE do nothing
    answer_ok = 1'b1;
    t_in = 8'd40;
    answer_btn = 1'b1;
    repeat (2) @(negedge clk);
    answer_btn = 1'b0;
    repeat (8) @(negedge clk);
    chk("idle_ans_busy", int'(busy), 0);
    chk("idle_ans_score", int'(score), 0);
    chk("idle_ans_tmr_rst_n", int'(tmr_rst_n), 0);

    // Game 2: full game to OVER
    press_start();
    for (int i = 2; i < 7; i++) play(vecs[i], i);
`ifndef ROUND_CTRL_BONUS_EN
    chk("game2_total", int'(score), 42);
`endif
    repeat (6) @(negedge clk);
    chk("over_hold_score", int'(score), m_score);
    chk("over_hold_round", int'(round), 5);
    chk("over_hold_game_over", int'(game_over), 1);
    chk("over_tmr_en", int'(tmr_en), 0);

    // Game 3: restart clears; start ignored while running; saturation
    press_start();
    start_btn = 1'b1;
    repeat (2) @(negedge clk);
    start_btn = 1'b0;
    repeat (6) @(negedge clk);
    chk("run_start_ignored_en", int'(tmr_en), 1);
    chk("run_start_ignored_rst_n", int'(tmr_rst_n), 1);
    for (int i = 7; i < 9; i++) play(vecs[i], i);
`ifndef ROUND_CTRL_BONUS_EN
    chk("sat_total", int'(s_score), 50);
    chk("nosat_total", int'(score), 60);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/round_ctrl.md
ROUND_CTRL -- requirements
Module: round_ctrl

Interface
REQ-001 SHALL have parameter ROUNDS, default 5, number of rounds per game (legal 1..15).
REQ-002 SHALL have parameter SCORE_MAX, default 4095, score saturation ceiling (fits 12 bits).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start_btn  input  1  asynchronous player start button, active-high.
REQ-006 SHALL have port answer_btn  input  1  asynchronous player answer button, active-high.
REQ-007 SHALL have port answer_ok  input  1  answer-correct flag, synchronous, sampled on answer detection.
REQ-008 SHALL have port t_in  input  8  seconds remaining, driven by the countdown timer.
REQ-009 SHALL have port t_done  input  1  countdown-expired flag, driven by the countdown timer.
REQ-010 SHALL have port tmr_rst_n  output  1  active-low reset driven to the countdown timer.
REQ-011 SHALL have port tmr_en  output  1  enable driven to the countdown timer.
REQ-012 SHALL have port score  output  12  accumulated game score.
REQ-013 SHALL have port round  output  4  completed-round count, 0..ROUNDS.
REQ-014 SHALL have port busy  output  1  high in ARM, RUN, SCORE and NEXT.
REQ-015 SHALL have port game_over  output  1  high in OVER only.

Function
REQ-016 SHALL pass start_btn and answer_btn each through a 2-flop synchronizer plus a rising-edge detector; edge pulse is 1 cycle, asserted 3 cycles after the button's rising edge.
REQ-017 SHALL implement FSM states IDLE, ARM, RUN, SCORE, NEXT, OVER; unreachable encodings SHALL go to IDLE.
REQ-018 IDLE: on start edge, clear score and round to 0, then go to ARM.
REQ-019 ARM: lasts exactly 1 cycle with tmr_rst_n=0, then go to RUN.
REQ-020 RUN: tmr_rst_n=1, tmr_en=1; on t_done go to NEXT; else on answer edge latch t_in and answer_ok, then go to SCORE.
REQ-021 RUN: if t_done and answer edge occur in the same cycle, t_done SHALL win; no points are awarded.
REQ-022 SCORE: lasts 1 cycle; if latched answer_ok=1, add latched t_in to score, saturating at SCORE_MAX; then go to NEXT.
REQ-023 NEXT: increment round; if the new value equals ROUNDS go to OVER, else go to ARM.
REQ-024 OVER: hold score and round; on start edge clear score and round, then go to ARM.
REQ-025 tmr_rst_n SHALL be 1 only in RUN and SCORE; tmr_en SHALL be 1 only in RUN.
REQ-026 Start edges in ARM, RUN, SCORE and NEXT, and answer edges outside RUN, SHALL be ignored.
REQ-027 All outputs SHALL be registered or pure state decodes, with no combinational path from input to output.

Reset
REQ-028 On rst=0, asynchronously: state=IDLE, score=0, round=0, tmr_rst_n=0, tmr_en=0, busy=0, game_over=0, synchronizer and edge flops=0.
REQ-029 Reset mid-game SHALL abandon the game with no partial score retained; after release the block waits in IDLE for a start edge.

Configuration
REQ-030 Macro ROUND_CTRL_BONUS_EN, when defined: in SCORE, a correct answer with latched t_in >= 20 SHALL add t_in+10 (saturating); other cases are unchanged.
REQ-031 Without ROUND_CTRL_BONUS_EN: no bonus logic, and scoring follows REQ-022 exactly.

Verification
REQ-032 Reset, then start pulse: tmr_rst_n low exactly 1 cycle, then RUN with tmr_en=1; busy=1, score=0, round=0.
REQ-033 Round 1: t_in=17, answer pulse with answer_ok=1 -> score=17, round=1, back to ARM; with bonus, t_in=25 -> score=35.
REQ-034 Timeout: t_done=1 with no answer -> score unchanged, round increments; same-cycle t_done and answer edge -> no points.
REQ-035 ROUNDS=5 full game, answers at t_in=30,0,12 (ok) and 9 (not ok) plus 1 timeout -> game_over=1, round=5, score=42; second start clears to 0.
REQ-036 Saturation: SCORE_MAX=50, two correct answers at t_in=30 -> score=50.
REQ-037 Assert rst low during RUN of round 3 -> all outputs at reset values immediately; answer pulses in IDLE are ignored.
